// File: rtl/cache_array_be_pkg.sv
// Shared constants, types and helpers for the byte-enabled dual-port cache array.
package cache_array_be_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

    function automatic int calc_nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic bit width_ok(input int data_width, input int byte_width);
        return (data_width % byte_width) == 0;
    endfunction

endpackage

// File: rtl/array_clear_seq.sv
// Clear sequencer: sweeps every entry once after reset or on request, then idles with ready high.
module array_clear_seq
    import cache_array_be_pkg::*;
#(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    output logic                   ready,
    output logic                   clr_we,
    output logic [INDEX_WIDTH-1:0] clr_addr
);

    // One extra counter bit keeps the terminal compare from aliasing with entry 0.
    localparam logic [INDEX_WIDTH:0] LAST_IDX = {1'b0, {INDEX_WIDTH{1'b1}}};

    clr_state_t             state;
    clr_state_t             state_nxt;
    logic [INDEX_WIDTH:0]   clr_idx;
    logic [INDEX_WIDTH:0]   clr_idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        clr_we      = 1'b0;
        ready       = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt   = ST_IDLE;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
                if (clear) begin
                    state_nxt   = ST_CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_idx_nxt = '0;
            end
        endcase
    end

    assign clr_addr = clr_idx[INDEX_WIDTH-1:0];

endmodule

// File: rtl/cache_array_be.sv
// True dual-port byte-enabled cache storage with deterministic collision policy and clear sweep.
module cache_array_be
    import cache_array_be_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INDEX_WIDTH = 6,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    output logic                             ready,
    input  logic                             en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
    input  logic [INDEX_WIDTH-1:0]           addr_a,
    input  logic [DATA_WIDTH-1:0]            data_a,
    output logic [DATA_WIDTH-1:0]            q_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
    input  logic [INDEX_WIDTH-1:0]           addr_b,
    input  logic [DATA_WIDTH-1:0]            data_b,
    output logic [DATA_WIDTH-1:0]            q_b
);

    localparam int NB    = calc_nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** INDEX_WIDTH;

    if (!width_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
        $error("cache_array_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   clr_we;
    logic [INDEX_WIDTH-1:0] clr_addr;

    logic                   acc_a;
    logic                   acc_b;
    logic                   wr_a;
    logic                   wr_b;
    logic                   wa_en;
    logic [INDEX_WIDTH-1:0] wa_addr;
    logic [DATA_WIDTH-1:0]  wa_data;
    logic [NB-1:0]          wa_be;
    logic [DATA_WIDTH-1:0]  rd_a;
    logic [DATA_WIDTH-1:0]  rd_b;

    array_clear_seq #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign acc_a = ready & en_a;
    assign acc_b = ready & en_b;
    assign wr_a  = acc_a & (|be_a);
    assign wr_b  = acc_b & (|be_b);

    // The sweep borrows port A's write path; ports are gated off while it runs.
    always_comb begin
        wa_en   = wr_a;
        wa_addr = addr_a;
        wa_data = data_a;
        wa_be   = be_a;
        if (clr_we) begin
            wa_en   = 1'b1;
            wa_addr = clr_addr;
            wa_data = INIT_VALUE;
            wa_be   = '1;
        end
    end

    assign rd_a = mem[addr_a];
    assign rd_b = mem[addr_b];

    // Port A lane writes follow port B so A wins overlapping lanes on a shared address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_b && be_b[i])
                mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wa_en && wa_be[i])
                mem[wa_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Readers see the pre-edge word, so a cross-port reader always gets the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (acc_a)
                q_a <= (RDW_MODE == RDW_WRITE_FIRST && wr_a) ? merge_bytes(rd_a, data_a, be_a) : rd_a;
            if (acc_b)
                q_b <= (RDW_MODE == RDW_WRITE_FIRST && wr_b) ? merge_bytes(rd_b, data_b, be_b) : rd_b;
        end
    end

endmodule
